// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first through one full-subtractor
// cell and a borrow flop, behind a start/busy/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q,   state_d;
   logic [WIDTH-1:0] a_sr_q,    a_sr_d;
   logic [WIDTH-1:0] b_sr_q,    b_sr_d;
   logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
   logic [WIDTH-1:0] diff_q,    diff_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic             br_q,      br_d;
   logic             bout_q,    bout_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;

   logic x_bit, y_bit, d_bit, br_next, accept;

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      diff_sr_d = diff_sr_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      br_d      = br_q;
      bout_d    = bout_q;
      busy_d    = busy_q;
      done_d    = done_q;

      x_bit   = a_sr_q[0];
      y_bit   = b_sr_q[0];
      d_bit   = x_bit ^ y_bit ^ br_q;
      br_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);

      // DONE also accepts a held start so results stream every WIDTH+1 cycles
      accept = start && (state_q == IDLE || state_q == DONE);

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
         RUN: begin
            diff_sr_d = {d_bit, diff_sr_q[WIDTH-1:1]};
            a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
            br_d      = br_next;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               diff_d  = {d_bit, diff_sr_q[WIDTH-1:1]};
               bout_d  = br_next;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase

      if (accept) begin
         state_d   = RUN;
         a_sr_d    = a;
         b_sr_d    = b;
         br_d      = bin;
         cnt_d     = '0;
         diff_sr_d = '0;
         diff_d    = '0;
         bout_d    = 1'b0;
         busy_d    = 1'b1;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         br_q      <= 1'b0;
         bout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         diff_sr_q <= diff_sr_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         br_q      <= br_d;
         bout_q    <= bout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random ops against an
// arithmetic model, back-to-back, mid-run reset, idle hold and a WIDTH=4 sweep.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start4 = 1'b0, bin4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;

   int n_cmp = 0;
   int n_bad = 0;
   int overlap_cnt = 0;
   int done4_cnt = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   always @(negedge clk) begin
      if ((busy8 && done8) || (busy4 && done4)) overlap_cnt++;
      if (done4) done4_cnt++;
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Starts one op on the WIDTH=8 instance, scrambles the operand inputs during RUN,
   // and reports the cycle (1 = first cycle after the accepting edge) in which done is seen.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output logic [7:0] od, output logic ob, output int lat, output int bcnt);
      @(negedge clk);
      a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      lat = 0; bcnt = 0;
      for (int k = 1; k <= 40; k++) begin
         if (busy8) bcnt++;
         if (done8) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      od = diff8; ob = bout8;
   endtask

   task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       output logic [3:0] od, output logic ob, output int lat);
      @(negedge clk);
      a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (done4) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      od = diff4; ob = bout4;
   endtask

   initial begin
      vec_t       tbl[6];
      logic [7:0] d, ea, eb;
      logic [3:0] d4;
      logic       bo, ebin, stable;
      int         lat, bcnt, ndone, last_done, cyc, exp_d, exp_bo;

      tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
      tbl[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

      // reset state
      #23;
      chk("reset_outputs8", {busy8, done8, diff8, bout8}, '0);
      chk("reset_outputs4", {busy4, done4, diff4, bout4}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run8(tbl[i].a, tbl[i].b, tbl[i].bin, d, bo, lat, bcnt);
         chk($sformatf("vec%0d_diff", i), d, tbl[i].d);
         chk($sformatf("vec%0d_bout", i), bo, tbl[i].bo);
         chk($sformatf("vec%0d_latency", i), lat, 9);
         chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      end

      for (int i = 0; i < 30; i++) begin
         ea = 8'($urandom); eb = 8'($urandom); ebin = 1'($urandom);
         exp_d  = (int'(ea) - int'(eb) - int'(ebin)) & 8'hFF;
         exp_bo = (int'(ea) < int'(eb) + int'(ebin)) ? 1 : 0;
         run8(ea, eb, ebin, d, bo, lat, bcnt);
         chk($sformatf("rand%0d_diff", i), d, exp_d);
         chk($sformatf("rand%0d_bout", i), bo, exp_bo);
         chk($sformatf("rand%0d_latency", i), lat, 9);
      end

      // start held high: results every 9 cycles, operands disturbed while computing
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      ndone = 0; last_done = 0;
      for (cyc = 1; cyc <= 60 && ndone < 3; cyc++) begin
         @(negedge clk);
         if (done8) begin
            ndone++;
            chk($sformatf("b2b%0d_diff", ndone), {bout8, diff8}, {1'b0, 8'h7F});
            chk($sformatf("b2b%0d_spacing", ndone), cyc - last_done, 9);
            last_done = cyc;
            a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
            if (ndone == 3) start8 = 1'b0;
         end else begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         end
      end
      chk("b2b_pulse_count", ndone, 3);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;

      // reset after 4 bits of a run aborts it
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_abort_busy", busy8, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {busy8, done8, diff8, bout8}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done8 || busy8) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run8(8'h10, 8'h01, 1'b0, d, bo, lat, bcnt);
      chk("post_abort_result", {bo, d}, {1'b0, 8'h0F});
      chk("post_abort_latency", lat, 9);

      // idle hold for 50 cycles
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (busy8 || done8 || diff8 !== 8'h0F || bout8 !== 1'b0) stable = 1'b0;
      end
      chk("idle_hold", stable, 1'b1);

      // WIDTH=4 sweep
      done4_cnt = 0;
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               run4(4'(ia), 4'(ib), 1'(ic), d4, bo, lat);
               exp_d  = (ia - ib - ic) & 4'hF;
               exp_bo = (ia < ib + ic) ? 1 : 0;
               if ({bo, d4} !== {1'(exp_bo), 4'(exp_d)} || lat != 5)
                  chk($sformatf("w4_a%0d_b%0d_c%0d", ia, ib, ic), {lat[7:0], bo, d4},
                      {8'd5, 1'(exp_bo), 4'(exp_d)});
               else
                  n_cmp++;
            end
      @(negedge clk);
      chk("w4_done_count", done4_cnt, 512);
      chk("busy_done_overlap", overlap_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
